// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite animation sequencer: playback mode
// encodings and the tick-divider width.
package sprite_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP     = 2'd0,
    MODE_PINGPONG = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_HOLD     = 2'd3
  } anim_mode_t;

  localparam int DIV_W = 8;

endpackage

// File: rtl/sprite_frame_table.sv
// Writable FRAMES x (DIM*DIM) bitmap store with one registered read port that
// owns the shape register. Defining SPRITE_MIRROR_EN adds a horizontal flip.
module sprite_frame_table
  import sprite_pkg::*;
#(
  parameter int DIM    = 5,
  parameter int FRAMES = 4,
  parameter int FW     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [FW-1:0]        wr_addr_i,
  input  logic [DIM*DIM-1:0]   wr_data_i,
  input  logic [FW-1:0]        rd_idx_i,
`ifdef SPRITE_MIRROR_EN
  input  logic                 mirror_i,
`endif
  output logic [DIM*DIM-1:0]   shape_o
);

  localparam int BITS = DIM * DIM;
  localparam logic [FW:0] FRAMES_C = (FW+1)'(FRAMES);

  logic [BITS-1:0] mem_q [FRAMES];
  logic [BITS-1:0] rd_word;
  logic [BITS-1:0] shape_q, shape_d;

`ifdef SPRITE_MIRROR_EN
  // Column c of every row moves to column DIM-1-c.
  function automatic logic [BITS-1:0] flip_rows(input logic [BITS-1:0] w);
    logic [BITS-1:0] f;
    f = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        f[r*DIM + (DIM-1-c)] = w[r*DIM + c];
      end
    end
    return f;
  endfunction
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FRAMES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && ({1'b0, wr_addr_i} < FRAMES_C)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // No write bypass: a same-cycle write to the displayed entry shows next cycle.
  always_comb begin
    rd_word = '0;
    if ({1'b0, rd_idx_i} < FRAMES_C) begin
      rd_word = mem_q[rd_idx_i];
    end
`ifdef SPRITE_MIRROR_EN
    shape_d = mirror_i ? flip_rows(rd_word) : rd_word;
`else
    shape_d = rd_word;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shape_q <= '0;
    end else begin
      shape_q <= shape_d;
    end
  end

  assign shape_o = shape_q;

endmodule

// File: rtl/sprite_animator.sv
// Sprite animation sequencer: tick divider, frame index / ping-pong direction
// and one-shot done pulse. Optional mirror input under SPRITE_MIRROR_EN.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int DIM    = 5,
  parameter int FRAMES = 4,
  parameter int DIV    = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        tick,
  input  logic                        enable,
  input  logic [1:0]                  mode,
  input  logic [$clog2(FRAMES)-1:0]   last_frame,
  input  logic                        restart,
`ifdef SPRITE_MIRROR_EN
  input  logic                        mirror,
`endif
  input  logic                        wr_en,
  input  logic [$clog2(FRAMES)-1:0]   wr_addr,
  input  logic [DIM*DIM-1:0]          wr_data,
  output logic [DIM*DIM-1:0]          shape,
  output logic [$clog2(FRAMES)-1:0]   frame_idx,
  output logic                        done
);

  localparam int FW = $clog2(FRAMES);
  localparam logic [FW-1:0]    IDX_MAX  = FW'(FRAMES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [FW-1:0]    idx_q, idx_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             done_q, done_d;

  anim_mode_t    mode_e;
  logic [FW-1:0] last_eff;
  logic          count_en;
  logic          advance;

  assign mode_e   = anim_mode_t'(mode);
  assign last_eff = (last_frame > IDX_MAX) ? IDX_MAX : last_frame;
  assign count_en = tick & enable & (mode_e != MODE_HOLD);
  assign advance  = count_en & (div_q == DIV_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      dir_q  <= 1'b1;
      div_q  <= '0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      dir_q  <= dir_d;
      div_q  <= div_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    dir_d  = dir_q;
    div_d  = div_q;
    done_d = 1'b0;
    if (restart) begin
      idx_d = '0;
      dir_d = 1'b1;
      div_d = '0;
    end else begin
      if (count_en) begin
        div_d = advance ? '0 : div_q + 1'b1;
      end
      if (advance) begin
        // An index stranded above a lowered last_frame restarts from 0.
        if (idx_q > last_eff) begin
          idx_d = '0;
          dir_d = 1'b1;
        end else begin
          case (mode_e)
            MODE_LOOP: begin
              idx_d = (idx_q == last_eff) ? '0 : idx_q + 1'b1;
            end
            MODE_PINGPONG: begin
              if (last_eff == '0) begin
                idx_d = '0;
              end else if (dir_q) begin
                if (idx_q == last_eff) begin
                  idx_d = idx_q - 1'b1;
                  dir_d = 1'b0;
                end else begin
                  idx_d = idx_q + 1'b1;
                end
              end else begin
                if (idx_q == '0) begin
                  idx_d = FW'(1);
                  dir_d = 1'b1;
                end else begin
                  idx_d = idx_q - 1'b1;
                end
              end
            end
            MODE_ONESHOT: begin
              if (idx_q < last_eff) begin
                idx_d = idx_q + 1'b1;
              end
            end
            default: begin
              idx_d = idx_q;
            end
          endcase
          done_d = (mode_e == MODE_ONESHOT) && (idx_d == last_eff) && (idx_q != last_eff);
        end
      end
    end
  end

  sprite_frame_table #(
    .DIM    (DIM),
    .FRAMES (FRAMES),
    .FW     (FW)
  ) u_table (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_idx_i  (idx_q),
`ifdef SPRITE_MIRROR_EN
    .mirror_i  (mirror),
`endif
    .shape_o   (shape)
  );

  assign frame_idx = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: two instances (DIV=1 and DIV=2) share
// all inputs; expected values are hand-derived per vector.
module tb_sprite_animator;

  localparam int DIM    = 5;
  localparam int FRAMES = 4;
  localparam int FW     = 2;
  localparam int BITS   = DIM * DIM;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset_n;
  logic            tick;
  logic            enable;
  logic [1:0]      mode;
  logic [FW-1:0]   last_frame;
  logic            restart;
  logic            wr_en;
  logic [FW-1:0]   wr_addr;
  logic [BITS-1:0] wr_data;
`ifdef SPRITE_MIRROR_EN
  logic            mirror;
`endif

  logic [BITS-1:0] shape1, shape2;
  logic [FW-1:0]   idx1, idx2;
  logic            done1, done2;

  sprite_animator #(.DIM(DIM), .FRAMES(FRAMES), .DIV(1)) u_div1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .tick       (tick),
    .enable     (enable),
    .mode       (mode),
    .last_frame (last_frame),
    .restart    (restart),
`ifdef SPRITE_MIRROR_EN
    .mirror     (mirror),
`endif
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .shape      (shape1),
    .frame_idx  (idx1),
    .done       (done1)
  );

  sprite_animator #(.DIM(DIM), .FRAMES(FRAMES), .DIV(2)) u_div2 (
    .clock      (clock),
    .reset_n    (reset_n),
    .tick       (tick),
    .enable     (enable),
    .mode       (mode),
    .last_frame (last_frame),
    .restart    (restart),
`ifdef SPRITE_MIRROR_EN
    .mirror     (mirror),
`endif
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .shape      (shape2),
    .frame_idx  (idx2),
    .done       (done2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    tick       = 1'b0;
    enable     = 1'b0;
    mode       = 2'd0;
    last_frame = 2'd3;
    restart    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
`ifdef SPRITE_MIRROR_EN
    mirror     = 1'b0;
`endif
    step();
    step();
    check_eq("rst shape", 32'(shape1), 32'h0);
    check_eq("rst idx", 32'(idx1), 32'h0);
    check_eq("rst done", 32'(done1), 32'h0);
    reset_n = 1'b1;
    step();
    check_eq("post-rst shape", 32'(shape1), 32'h0);

    // Load frames 0..3 with 1,2,4,8; frame 0 is displayed.
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_addr = FW'(i);
      wr_data = BITS'(1 << i);
      step();
      if (i == 0) check_eq("load no bypass", 32'(shape1), 32'h0);
      if (i == 1) check_eq("load frame0 shown", 32'(shape1), 32'h1);
    end
    wr_en = 1'b0;

    // LOOP, L=3, on both dividers.
    do_restart();
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick = 1'b1;
      step();
      check_eq($sformatf("loop d1 idx k=%0d", k), 32'(idx1), 32'(k % 4));
      check_eq($sformatf("loop d2 idx k=%0d", k), 32'(idx2), 32'((k / 2) % 4));
      check_eq($sformatf("loop d1 shape k=%0d", k), 32'(shape1), 32'(1 << ((k - 1) % 4)));
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("pre-freeze d1", 32'(idx1), 32'h1);

    // enable low, then HOLD: no movement, divider of d2 frozen at 1.
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick = 1'b1;
      step();
    end
    check_eq("enable0 d1", 32'(idx1), 32'h1);
    check_eq("enable0 d2", 32'(idx2), 32'h0);
    enable = 1'b1;
    mode   = 2'd3;
    for (int k = 0; k < 10; k++) begin
      step();
    end
    check_eq("hold d1", 32'(idx1), 32'h1);
    check_eq("hold d2", 32'(idx2), 32'h0);
    mode = 2'd0;
    step();
    tick = 1'b0;
    check_eq("unfreeze d1", 32'(idx1), 32'h2);
    check_eq("unfreeze d2", 32'(idx2), 32'h1);

    // PINGPONG, DIV=1, L=3.
    mode = 2'd1;
    do_restart();
    begin
      automatic int pp_exp[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
      for (int k = 0; k < 8; k++) begin
        tick = 1'b1;
        step();
        check_eq($sformatf("pingpong k=%0d", k), 32'(idx1), 32'(pp_exp[k]));
      end
    end
    tick = 1'b0;
    last_frame = 2'd0;
    do_restart();
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      step();
      check_eq($sformatf("pingpong L0 k=%0d", k), 32'(idx1), 32'h0);
    end
    tick = 1'b0;

    // ONESHOT, L=2.
    mode       = 2'd2;
    last_frame = 2'd2;
    do_restart();
    tick = 1'b1;
    step();
    check_eq("oneshot t1 done", 32'(done1), 32'h0);
    step();
    check_eq("oneshot t2 idx", 32'(idx1), 32'h2);
    check_eq("oneshot t2 done", 32'(done1), 32'h1);
    tick = 1'b0;
    step();
    check_eq("oneshot pulse width", 32'(done1), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1;
      step();
      check_eq($sformatf("oneshot parked done k=%0d", k), 32'(done1), 32'h0);
      check_eq($sformatf("oneshot parked idx k=%0d", k), 32'(idx1), 32'h2);
    end
    tick = 1'b0;
    do_restart();
    check_eq("oneshot restart idx", 32'(idx1), 32'h0);
    tick = 1'b1;
    step();
    check_eq("oneshot rearm t1", 32'(done1), 32'h0);
    step();
    check_eq("oneshot rearm t2", 32'(done1), 32'h1);
    tick = 1'b0;

    // restart and tick together, LOOP L=3.
    mode       = 2'd0;
    last_frame = 2'd3;
    do_restart();
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      step();
    end
    check_eq("pre-restart d2", 32'(idx2), 32'h1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_eq("restart+tick d1", 32'(idx1), 32'h0);
    check_eq("restart+tick d2", 32'(idx2), 32'h0);
    step();
    check_eq("restart div cleared d2 t1", 32'(idx2), 32'h0);
    step();
    check_eq("restart div cleared d2 t2", 32'(idx2), 32'h1);
    tick = 1'b0;

    // Lower last_frame under a running index.
    do_restart();
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
    last_frame = 2'd1;
    step();
    check_eq("lowered L idle", 32'(idx1), 32'h3);
    tick = 1'b1;
    step();
    check_eq("lowered L wrap", 32'(idx1), 32'h0);
    step();
    check_eq("lowered L t2", 32'(idx1), 32'h1);
    step();
    check_eq("lowered L t3", 32'(idx1), 32'h0);
    tick = 1'b0;

    // Write to the displayed frame during playback.
    last_frame = 2'd3;
    do_restart();
    step();
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_data = 25'h1ABCDEF;
    step();
    wr_en = 1'b0;
    check_eq("live write edge1", 32'(shape1), 32'h1);
    step();
    check_eq("live write edge2", 32'(shape1), 32'h1ABCDEF);
    wr_en   = 1'b1;
    wr_data = 25'h0000001;
    step();
    wr_en = 1'b0;
    step();

`ifdef SPRITE_MIRROR_EN
    mirror = 1'b1;
    step();
    check_eq("mirror frame0", 32'(shape1), 32'h10);
    mirror = 1'b0;
    step();
    check_eq("mirror off", 32'(shape1), 32'h1);
`endif

    // Asynchronous reset mid-sequence.
    do_restart();
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
    check_eq("pre-async idx", 32'(idx1), 32'h3);
    reset_n = 1'b0;
    #1;
    check_eq("async rst idx1", 32'(idx1), 32'h0);
    check_eq("async rst shape1", 32'(shape1), 32'h0);
    check_eq("async rst done1", 32'(done1), 32'h0);
    check_eq("async rst idx2", 32'(idx2), 32'h0);
    check_eq("async rst shape2", 32'(shape2), 32'h0);
    #2;
    reset_n = 1'b1;
    step();
    tick = 1'b1;
    step();
    check_eq("post-rst full DIV t1", 32'(idx2), 32'h0);
    step();
    check_eq("post-rst full DIV t2", 32'(idx2), 32'h1);
    tick = 1'b0;
    step();
    check_eq("post-rst table cleared", 32'(shape2), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_animator.md
# sprite_animator

Parametrised sprite animation sequencer for the maze renderer. It holds a small writable table of DIM×DIM monochrome bitmaps and steps through them on a frame-advance strobe. Supported playback modes are loop, ping-pong, one-shot and hold, with a programmable tick divider. The registered bitmap feeds the tile/sprite drawer directly, one instance per animated object (pellets, power pellets, ghosts).

## Interface
Parameters:
- DIM, 5: bitmap edge length; shape width is DIM*DIM bits, row-major, bit 0 = row 0 col 0.
- FRAMES, 4: frame table depth, 2..16.
- DIV, 1: tick strobes per frame advance, 1..255.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  advance strobe (typically one pulse per video frame).
- enable  in  1  when low, divider and frame index freeze.
- mode  in  2  0 LOOP, 1 PINGPONG, 2 ONESHOT, 3 HOLD.
- last_frame  in  FW  highest frame index played; FW = $clog2(FRAMES).
- restart  in  1  synchronous restart strobe.
- wr_en  in  1  frame table write strobe.
- wr_addr  in  FW  frame table write index.
- wr_data  in  DIM*DIM  bitmap to write.
- shape  out  DIM*DIM  registered bitmap of current frame.
- frame_idx  out  FW  current frame index.
- done  out  1  one-cycle pulse, ONESHOT completion.

## Operation
- Effective last L = min(last_frame, FRAMES-1).
- Divider div_cnt (8 bit): increments on tick & enable & mode≠HOLD. On tick with div_cnt==DIV-1, it clears and generates an advance.
- Direction flag dir (1 = up) is used by PINGPONG only. It is retained across mode changes.
- Advance rules:
  - LOOP: idx==L → 0, else idx+1.
  - PINGPONG up: idx==L → idx-1 and dir=0, else idx+1.
  - PINGPONG down: idx==0 → 1 and dir=1, else idx-1.
  - PINGPONG with L==0: stays at 0.
  - ONESHOT: idx<L → idx+1. At L, stays at L.
  - HOLD: never advances; divider frozen.
- Out-of-range: if idx>L (last_frame lowered live), the next advance in any mode goes to 0 with dir=1.
- done: asserts in the cycle frame_idx first becomes L under ONESHOT. No pulse while already parked at L. restart re-arms it.
- restart has priority over tick/advance: idx=0, dir=1, div_cnt=0, done=0.
- Frame table write: wr_en writes entry wr_addr. Out-of-range addresses (≥FRAMES) are ignored. Writes are independent of playback.

## Timing
- Reset values: frame_idx=0, dir=1, div_cnt=0, done=0, shape=0, all table entries 0.
- Advance decided on the tick cycle; frame_idx updates at the next clock edge.
- shape <= table[frame_idx] every cycle, so shape lags frame_idx by one cycle.
- Write at cycle t lands in the table at edge t+1. It appears on shape at edge t+2 if that frame is current.
- Simultaneous write and read of the same entry: shape shows the old data for that cycle. No bypass.
- reset_n assertion mid-operation clears all state immediately. The first advance after release needs a full DIV ticks.

## Configuration
- SPRITE_MIRROR_EN defined: adds input port mirror (1 bit). While high, the shape register loads a horizontally flipped bitmap (col c → DIM-1-c per row). Latency is unchanged. Used for left-facing sprites.
- SPRITE_MIRROR_EN undefined: no mirror port and no flip logic; shape is the table entry verbatim.

## Structure
- Package sprite_pkg:
  - mode encodings MODE_LOOP/MODE_PINGPONG/MODE_ONESHOT/MODE_HOLD.
  - anim_mode_t typedef.
  - divider width constant.
- Sub-module sprite_frame_table:
  - FRAMES×(DIM*DIM) register file with async reset.
  - One write port, one registered read port (owns the shape register and optional mirror).
- The sequencer FSM (index, dir, divider, done) stays in sprite_animator.

## Test plan
- Reset/load: write frames 0..3 with 25'h0000001..25'h0000008. Expect shape=0 immediately after reset, then shape=25'h0000001 two cycles after enable.
- LOOP, DIV=2, L=3: 16 ticks → frame_idx sequence 0,0,1,1,2,2,3,3,0,…, each change one cycle after the tick.
- PINGPONG, DIV=1, L=3: 8 ticks → 1,2,3,2,1,0,1,2. With L=0, idx stays 0.
- ONESHOT, L=2: done pulses once on reaching idx 2, and stays low for 5 further ticks. restart plus 2 ticks → done pulses again.
- Boundaries: restart and tick in the same cycle → idx=0, div_cnt=0. Lower last_frame from 3 to 1 while idx=3 → next advance 0. Set enable=0 or HOLD → no change over 10 ticks. Assert reset_n mid-sequence → all outputs 0 the same cycle.
- Write to the current frame during playback → new bitmap visible on shape exactly two edges later. With SPRITE_MIRROR_EN, mirror=1 on 25'h0000001 → shape=25'h0000010.
